// File: rtl/rx_pkg.sv
// Shared types and constants for the receive-side frame path.
package rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        PAYLOAD,
        DROP
    } rxState_e;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;

    localparam int DEF_PRE_MIN    = 7;
    localparam int DEF_GAP_CYCLES = 6;
    localparam int DEF_MIN_LEN    = 64;
    localparam int DEF_MAX_LEN    = 1518;

endpackage

// File: rtl/rx_gap_timer.sv
// Idle-gap detector: pulses gapOut once on the GAP_CYCLES-th consecutive idle
// cycle, then stays quiet until a valid byte restarts the count.
module rx_gap_timer #(
    parameter int GAP_CYCLES = 6
) (
    input  logic clkIn,
    input  logic rstIn,
    input  logic dataValidIn,
    output logic gapOut
);

    localparam int              CNT_W    = $clog2(GAP_CYCLES + 1);
    localparam logic [CNT_W-1:0] GAP_SAT  = CNT_W'(GAP_CYCLES);
    localparam logic [CNT_W-1:0] GAP_FIRE = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] gapCnt;

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples the pre-edge value of every other register.
    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            gapCnt <= '0;
        end else if (dataValidIn) begin
            gapCnt <= '0;
        end else if (gapCnt != GAP_SAT) begin
            gapCnt <= gapCnt + CNT_ONE;
        end
    end

    // A valid byte on the firing cycle suppresses the pulse and counts as data.
    assign gapOut = !dataValidIn && (gapCnt == GAP_FIRE);

endmodule

// File: rtl/rx_frame_ctrl.sv
// Receive frame sequencer: strips preamble/SFD, forwards DA..FCS with SOF/EOF,
// delimits frames on idle gaps and flags runt/oversize frames.
module rx_frame_ctrl
    import rx_pkg::*;
#(
    parameter int PRE_MIN    = DEF_PRE_MIN,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int MIN_LEN    = DEF_MIN_LEN,
    parameter int MAX_LEN    = DEF_MAX_LEN,
    parameter int LEN_W      = 11
) (
    input  logic             clkIn,
    input  logic             rstIn,
    input  logic [7:0]       dataIn,
    input  logic             dataValidIn,
    output logic [7:0]       dataOut,
    output logic             dataValidOut,
    output logic             sofOut,
    output logic             eofOut,
    output logic             errOut,
    output logic [LEN_W-1:0] frameLenOut,
    output logic [15:0]      dropCntOut
);

    localparam int               PRE_W   = $clog2(PRE_MIN + 1);
    localparam logic [PRE_W-1:0] PRE_SAT = PRE_W'(PRE_MIN);
    localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    rxState_e         state, nextState;
    logic             gap;
    logic [PRE_W-1:0] preCnt;
    logic [LEN_W-1:0] lenCnt;
    logic [7:0]       holdByte;
    logic             holdValid;

    logic isPre, isSfd, preOk, atMax;
    logic loadHold, emitByte, emitSof, emitEof, emitErr, enterDrop;

    assign isPre = (dataIn == PREAMBLE_BYTE);
    assign isSfd = (dataIn == SFD_BYTE);
    assign preOk = (preCnt >= PRE_SAT);
    assign atMax = (lenCnt == LEN_MAX);

    rx_gap_timer #(
        .GAP_CYCLES(GAP_CYCLES)
    ) gapTimer (
        .clkIn      (clkIn),
        .rstIn      (rstIn),
        .dataValidIn(dataValidIn),
        .gapOut     (gap)
    );

    always_ff @(posedge clkIn) begin
        if (rstIn) state <= IDLE;
        else       state <= nextState;
    end

    // NOTE: every combinational output gets a default before the case, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (dataValidIn) nextState = isPre ? PREAMBLE : DROP;
            end
            PREAMBLE: begin
                if (dataValidIn) begin
                    if (isPre)               nextState = PREAMBLE;
                    else if (isSfd && preOk) nextState = PAYLOAD;
                    else                     nextState = DROP;
                end else if (gap) begin
                    nextState = IDLE;
                end
            end
            PAYLOAD: begin
                if (dataValidIn && atMax) nextState = DROP;
                else if (gap)             nextState = IDLE;
            end
            DROP: begin
                if (gap) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // The held byte leaves when its successor arrives, or with EOF on gap/overflow.
    always_comb begin
        loadHold = 1'b0;
        emitByte = 1'b0;
        emitSof  = 1'b0;
        emitEof  = 1'b0;
        emitErr  = 1'b0;
        if (state == PAYLOAD) begin
            if (dataValidIn) begin
                emitByte = holdValid;
                emitSof  = (lenCnt == LEN_ONE);
                if (atMax) begin
                    emitEof = 1'b1;
                    emitErr = 1'b1;
                end else begin
                    loadHold = 1'b1;
                end
            end else if (gap) begin
                emitByte = holdValid;
                emitSof  = (lenCnt == LEN_ONE);
                emitEof  = holdValid;
                emitErr  = (lenCnt < LEN_MIN);
            end
        end
    end

    assign enterDrop = (nextState == DROP) && (state != DROP);

    // NOTE: the hold byte is reset with everything else, so nothing from an
    // abandoned frame can resurface after rstIn.
    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            dataOut      <= '0;
            dataValidOut <= 1'b0;
            sofOut       <= 1'b0;
            eofOut       <= 1'b0;
            errOut       <= 1'b0;
            frameLenOut  <= '0;
            dropCntOut   <= '0;
            preCnt       <= '0;
            lenCnt       <= '0;
            holdByte     <= '0;
            holdValid    <= 1'b0;
        end else begin
            dataValidOut <= emitByte;
            dataOut      <= emitByte ? holdByte : 8'h00;
            sofOut       <= emitByte && emitSof;
            eofOut       <= emitEof;
            errOut       <= emitEof && emitErr;
            frameLenOut  <= emitEof ? lenCnt : '0;

            case (state)
                IDLE: begin
                    if (dataValidIn && isPre) preCnt <= PRE_ONE;
                end
                PREAMBLE: begin
                    if (dataValidIn && isPre && !preOk) preCnt <= preCnt + PRE_ONE;
                    if (nextState == PAYLOAD) begin
                        lenCnt    <= '0;
                        holdValid <= 1'b0;
                    end
                end
                PAYLOAD: begin
                    if (loadHold) begin
                        holdByte  <= dataIn;
                        holdValid <= 1'b1;
                        lenCnt    <= lenCnt + LEN_ONE;
                    end else if (nextState != PAYLOAD) begin
                        holdValid <= 1'b0;
                    end
                end
                default: ;
            endcase

            if (enterDrop && dropCntOut != 16'hFFFF) dropCntOut <= dropCntOut + 16'd1;
        end
    end

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Directed bench for rx_frame_ctrl: stimulus pushes expected output beats into a
// queue, a negedge monitor pops and compares each beat the DUT presents.
module tb_rx_frame_ctrl;

    localparam int          LEN_W = 11;
    localparam logic [7:0]  PRE   = 8'h55;
    localparam logic [7:0]  SFD   = 8'hD5;

    typedef struct packed {
        logic [7:0]       data;
        logic             sof;
        logic             eof;
        logic             err;
        logic [LEN_W-1:0] len;
    } outBeat_t;

    logic             clkIn = 1'b0;
    logic             rstIn;
    logic [7:0]       dataIn;
    logic             dataValidIn;
    logic [7:0]       dataOut;
    logic             dataValidOut;
    logic             sofOut;
    logic             eofOut;
    logic             errOut;
    logic [LEN_W-1:0] frameLenOut;
    logic [15:0]      dropCntOut;

    int       nChecks = 0;
    int       nFails  = 0;
    outBeat_t expQ[$];
    outBeat_t expBeat;
    outBeat_t gotBeat;

    rx_frame_ctrl #(
        .PRE_MIN(7), .GAP_CYCLES(6), .MIN_LEN(64), .MAX_LEN(1518), .LEN_W(LEN_W)
    ) dut (
        .clkIn       (clkIn),
        .rstIn       (rstIn),
        .dataIn      (dataIn),
        .dataValidIn (dataValidIn),
        .dataOut     (dataOut),
        .dataValidOut(dataValidOut),
        .sofOut      (sofOut),
        .eofOut      (eofOut),
        .errOut      (errOut),
        .frameLenOut (frameLenOut),
        .dropCntOut  (dropCntOut)
    );

    always #2 clkIn = ~clkIn;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Beats k=1..count carry seed+k-1; the last one closes the frame if 'closed'.
    task automatic expectBytes(input int count, input logic [7:0] seed,
                               input bit closed, input bit isErr);
        outBeat_t e;
        for (int k = 1; k <= count; k++) begin
            e.data = seed + 8'(k - 1);
            e.sof  = (k == 1);
            e.eof  = closed && (k == count);
            e.err  = e.eof && isErr;
            e.len  = e.eof ? LEN_W'(count) : '0;
            expQ.push_back(e);
        end
    endtask

    task automatic sendByte(input logic [7:0] b, input int idle);
        @(negedge clkIn);
        dataIn      = b;
        dataValidIn = 1'b1;
        for (int i = 0; i < idle; i++) begin
            @(negedge clkIn);
            dataValidIn = 1'b0;
        end
    endtask

    task automatic sendFrame(input int nPre, input logic [7:0] sfd, input int nPay,
                             input logic [7:0] seed, input bit jitter, input int tailIdle);
        for (int i = 0; i < nPre; i++) sendByte(PRE, 1);
        sendByte(sfd, jitter ? 2 : 1);
        for (int k = 1; k <= nPay; k++)
            sendByte(seed + 8'(k - 1), (k == nPay) ? tailIdle : (jitter ? 1 + (k % 2) : 1));
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, " dataOut"},      32'(dataOut),      32'd0);
        check({tag, " dataValidOut"}, 32'(dataValidOut), 32'd0);
        check({tag, " sofOut"},       32'(sofOut),       32'd0);
        check({tag, " eofOut"},       32'(eofOut),       32'd0);
        check({tag, " errOut"},       32'(errOut),       32'd0);
        check({tag, " frameLenOut"},  32'(frameLenOut),  32'd0);
        check({tag, " dropCntOut"},   32'(dropCntOut),   32'd0);
    endtask

    always @(negedge clkIn) begin
        if (rstIn === 1'b0 && dataValidOut === 1'b1) begin
            gotBeat = {dataOut, sofOut, eofOut, errOut, frameLenOut};
            if (expQ.size() == 0) begin
                check("unexpected output beat", 32'(gotBeat), 32'hFFFF_FFFF);
            end else begin
                expBeat = expQ.pop_front();
                check("output beat {data,sof,eof,err,len}", 32'(gotBeat), 32'(expBeat));
            end
        end else if (rstIn === 1'b0 && (sofOut === 1'b1 || eofOut === 1'b1)) begin
            check("marker without dataValidOut", {30'd0, sofOut, eofOut}, 32'd0);
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstIn       = 1'b1;
        dataIn      = 8'h00;
        dataValidIn = 1'b0;
        repeat (3) @(negedge clkIn);
        checkAllZero("reset");
        rstIn = 1'b0;
        repeat (8) @(negedge clkIn);

        expectBytes(64, 8'h00, 1, 0);
        sendFrame(7, SFD, 64, 8'h00, 1, 10);
        check("dropCnt after good frame", 32'(dropCntOut), 32'd0);

        expectBytes(63, 8'h40, 1, 1);
        sendFrame(7, SFD, 63, 8'h40, 1, 10);

        expectBytes(1, 8'hA5, 1, 1);
        sendFrame(7, SFD, 1, 8'hA5, 0, 10);

        expectBytes(1518, 8'h10, 1, 0);
        sendFrame(9, SFD, 1518, 8'h10, 1, 10);
        check("dropCnt after max-length frame", 32'(dropCntOut), 32'd0);

        expectBytes(1518, 8'h20, 1, 1);
        sendFrame(7, SFD, 1519, 8'h20, 1, 10);
        check("dropCnt after oversize", 32'(dropCntOut), 32'd1);

        sendFrame(5, SFD, 70, 8'h30, 1, 10);
        check("dropCnt after short preamble", 32'(dropCntOut), 32'd2);
        expectBytes(64, 8'h80, 1, 0);
        sendFrame(7, SFD, 64, 8'h80, 1, 10);

        for (int i = 0; i < 3; i++) sendByte(PRE, (i == 2) ? 10 : 1);
        check("dropCnt after abandoned preamble", 32'(dropCntOut), 32'd2);
        sendByte(8'hAB, 10);
        check("dropCnt after junk byte", 32'(dropCntOut), 32'd3);

        expectBytes(64, 8'hC0, 1, 0);
        expectBytes(64, 8'h07, 1, 0);
        sendFrame(7, SFD, 64, 8'hC0, 0, 6);
        sendFrame(7, SFD, 64, 8'h07, 0, 10);
        check("dropCnt after back-to-back", 32'(dropCntOut), 32'd3);

        expectBytes(19, 8'h60, 0, 0);
        sendFrame(7, SFD, 20, 8'h60, 0, 1);
        @(negedge clkIn);
        rstIn = 1'b1;
        @(negedge clkIn);
        checkAllZero("mid-frame reset");
        rstIn = 1'b0;
        check("queue empty after reset", 32'(expQ.size()), 32'd0);

        expectBytes(64, 8'hE0, 1, 0);
        sendFrame(7, SFD, 64, 8'hE0, 1, 10);
        repeat (20) @(negedge clkIn);
        check("all expected beats seen", 32'(expQ.size()), 32'd0);
        check("final dropCnt", 32'(dropCntOut), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
